// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, credit-limited imem requests, 2-entry instruction FIFO, redirect flush
module fetch_unit #(
  parameter int mode = 32,
  parameter logic [mode-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [mode-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [mode-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     instruction,
  output logic [mode-1:0] inst_pc
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [mode-1:0] WORD_MASK = {{(mode-2){1'b1}}, 2'b00};

  state_t          state;
  logic [mode-1:0] pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop_cnt;
  logic [1:0]      fifo_count;
  logic [mode-1:0] iq_pc [2];
  logic            iq_wr, iq_rd;
  logic [31:0]     f_inst [2];
  logic [mode-1:0] f_pc [2];
  logic            f_wr, f_rd;

  logic            pop, grant, rsp, keep;
  logic [2:0]      credit_use;

  assign inst_valid  = (fifo_count != 2'd0) & ~redirect_valid;
  assign pop         = inst_valid & inst_ready;
  // Counts a slot freed by this cycle's pop, so a full pipeline keeps one fetch per cycle.
  assign credit_use  = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
  assign imem_req    = (state == FETCH) & ~redirect_valid & (credit_use < 3'd2);
  assign imem_addr   = pc & WORD_MASK;
  assign grant       = imem_req & imem_gnt;
  // Responses with nothing outstanding are strays from before a reset.
  assign rsp         = imem_rvalid & (outstanding != 2'd0);
  assign keep        = rsp & (drop_cnt == 2'd0) & ~redirect_valid;
  assign instruction = f_inst[f_rd];
  assign inst_pc     = f_pc[f_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      fifo_count  <= 2'd0;
      iq_pc[0]    <= '0;
      iq_pc[1]    <= '0;
      iq_wr       <= 1'b0;
      iq_rd       <= 1'b0;
      f_inst[0]   <= '0;
      f_inst[1]   <= '0;
      f_pc[0]     <= '0;
      f_pc[1]     <= '0;
      f_wr        <= 1'b0;
      f_rd        <= 1'b0;
    end else begin
      state <= FETCH;

      if (redirect_valid) pc <= redirect_pc & WORD_MASK;
      else if (grant)     pc <= pc + mode'(4);

      outstanding <= outstanding + {1'b0, grant} - {1'b0, rsp};

      if (grant) begin
        iq_pc[iq_wr] <= pc;
        iq_wr        <= ~iq_wr;
      end
      if (rsp) iq_rd <= ~iq_rd;

      // Every fetch still in flight at a redirect belongs to the old path.
      if (redirect_valid)                 drop_cnt <= outstanding - {1'b0, rsp};
      else if (rsp && drop_cnt != 2'd0)   drop_cnt <= drop_cnt - 2'd1;

      if (redirect_valid) begin
        fifo_count <= 2'd0;
        f_rd       <= f_wr;
      end else begin
        if (keep) begin
          f_inst[f_wr] <= imem_rdata;
          f_pc[f_wr]   <= iq_pc[iq_rd];
          f_wr         <= ~f_wr;
        end
        if (pop) f_rd <= ~f_rd;
        fifo_count <= fifo_count + {1'b0, keep} - {1'b0, pop};
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

RV32I instruction fetch stage. It holds the program counter and issues word reads to instruction memory. Returned instruction words and their PCs are buffered and handed to decode, where opcode/immediate extraction happens, through a valid/ready handshake. Branch/jump redirects from execute flush the buffered and in-flight fetches.

## Interface
- mode, 32: PC/address width in bits; instruction width is fixed at 32.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  mode  word address being requested; bits [1:0] always 0
- imem_gnt  in  1  memory accepted request this cycle (counts only when imem_req=1)
- imem_rvalid  in  1  read data valid; responses return in request order, earliest 1 cycle after grant
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  execute-stage PC redirect (taken branch, jal, jalr)
- redirect_pc  in  mode  redirect target; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- instruction  out  32  instruction word to decode
- inst_pc  out  mode  address of the presented instruction

## Operation
- States: IDLE (entered on reset, no request) -> FETCH (unconditionally, next cycle). FETCH is terminal; it is only left through reset.
- pc register: reset = RESET_PC. imem_addr = {pc[mode-1:2],2'b00}.
- Issued-PC queue: 2 entries. Each granted request pushes its pc; each response pops it and pairs it with imem_rdata.
- Instruction FIFO: 2 entries of {instruction, pc}. Head drives instruction/inst_pc.
- outstanding: count of granted requests with no response yet, 0..2.
- pop = inst_valid & inst_ready.
- imem_req = (state==FETCH) & ~redirect_valid & (outstanding + fifo_count - pop < 2).
- On imem_req & imem_gnt: pc <= pc + 4 (mod 2^mode, wraps), outstanding += 1.
- On imem_rvalid:
  - drop_cnt > 0: discard the response, drop_cnt -= 1, outstanding -= 1.
  - Otherwise: push to FIFO, outstanding -= 1.
- A response is never discarded for lack of space; the credit rule guarantees room.
- inst_valid = (fifo_count != 0) & ~redirect_valid.
- Redirect cycle:
  - pc <= {redirect_pc[mode-1:2],2'b00}.
  - FIFO cleared; any pop and any push that cycle are cancelled.
  - drop_cnt <= outstanding, minus 1 if imem_rvalid is high that cycle; that same-cycle response is discarded.
  - The issued-PC queue is treated the same way: dropped entries are popped as their responses arrive.
- Redirect while drop_cnt > 0: drop_cnt recomputed by the same rule; all older in-flight responses are still discarded.
- Reset asserted mid-operation: all state cleared immediately. Any response that arrives afterwards is ignored, because outstanding=0 and drop_cnt=0 and imem_rvalid with outstanding=0 is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0. Internal state: pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO and queue empty, state=IDLE.
- First request: the first cycle after rst_n rises is IDLE; the second cycle is FETCH with imem_req=1.
- Response timing: a response at rising edge N gives inst_valid=1 during cycle N+1 (1 cycle registered latency).
- Throughput: with 1-cycle memory and inst_ready held high, one instruction per cycle is sustained. This relies on the combinational inst_ready -> imem_req path.
- Back-pressure: with inst_ready=0, at most 2 words are buffered and imem_req falls to 0. Head outputs stay stable while inst_valid=1 and inst_ready=0.
- Redirect: imem_req=0 and inst_valid=0 in the redirect cycle; the next cycle requests redirect_pc.

## Test plan
- Reset/boot: hold rst_n=0 3 cycles, release; gnt=1, 1-cycle latency, rdata sequence 0x002081B3, 0x00508113, 0x02812183. Required: imem_addr 0x0, 0x4, 0x8 on consecutive cycles; inst_valid/instruction/inst_pc in order, first on cycle 3 after release.
- Back-pressure: inst_ready=0 for 5 cycles. Required: exactly 2 words buffered, imem_req=0, head 0x002081B3/pc 0x0 stable. On release, no loss and no duplication.
- Redirect with 2 in flight: use 3-cycle memory latency; while 2 fetches (0x8, 0xC) are outstanding, pulse redirect_valid with redirect_pc=0x100. Required: both late responses discarded; next inst_pc=0x100.
- Misaligned target: redirect_pc=0x0000_0106. Required: imem_addr=0x104.
- Redirect coinciding with rvalid and inst_ready: the same-cycle response is discarded, no pop occurs, drop_cnt = outstanding-1; the first delivered instruction is from the target.
- Async reset mid-stream: drop rst_n between clock edges while 2 fetches are outstanding. Required: outputs go to reset values immediately; stray rvalid after release is ignored; fetch restarts at RESET_PC.
